// File: rtl/mio_bus_responder.sv
// Responder for the CPU memory/IO handshake: decodes word accesses to RAM,
// GPIO and timer, applies per-target latency and returns a one-cycle mio_ready.
module mio_bus_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_mio,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {T_RAM, T_GPIO, T_TMR, T_UNM} target_t;

    localparam logic [3:0] LAT_M2 = 4'(RAM_LAT - 2);

    state_t              state, state_nx;
    target_t             in_tgt, tgt_q, cur_tgt;
    logic                w_q, cur_w;
    logic [31:0]         wdata_q;
    logic [RAM_AW-1:0]   idx_q, cur_idx;
    logic [3:0]          lat_cnt, lat_cnt_nx;
    logic [31:0]         timer;
    logic                commit;
    logic [31:0]         mem [(1 << RAM_AW)];

    always_comb begin
        in_tgt = T_UNM;
        if (addr[1:0] == 2'b00) begin
            if (addr[31:RAM_AW+2] == '0)     in_tgt = T_RAM;
            else if (addr == 32'hE000_0000) in_tgt = T_GPIO;
            else if (addr == 32'hF000_0000) in_tgt = T_TMR;
        end
    end

    // Single-cycle accesses enter RESP straight from IDLE, so the read/error
    // path must see the live request rather than the not-yet-latched copy.
    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        mio_ready  = 1'b0;
        cur_tgt    = tgt_q;
        cur_idx    = idx_q;
        cur_w      = w_q;
        case (state)
            IDLE: begin
                cur_tgt = in_tgt;
                cur_idx = addr[RAM_AW+1:2];
                cur_w   = mem_w;
                if (cpu_mio) begin
                    if (in_tgt == T_RAM && RAM_LAT > 1) begin
                        state_nx   = WAIT;
                        lat_cnt_nx = LAT_M2;
                    end else begin
                        state_nx = RESP;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd0) state_nx = RESP;
                else                 lat_cnt_nx = lat_cnt - 4'd1;
            end
            RESP: begin
                mio_ready = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign commit = (state == RESP) && w_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            tgt_q    <= T_UNM;
            w_q      <= 1'b0;
            wdata_q  <= '0;
            idx_q    <= '0;
            rdata    <= '0;
            gpio_out <= '0;
            timer    <= '0;
            bus_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_cnt_nx;
            if (state == IDLE && cpu_mio) begin
                tgt_q   <= in_tgt;
                w_q     <= mem_w;
                wdata_q <= wdata;
                idx_q   <= addr[RAM_AW+1:2];
            end
            if (state_nx == RESP) begin
                if (!cur_w) begin
                    case (cur_tgt)
                        T_RAM:   rdata <= mem[cur_idx];
                        T_GPIO:  rdata <= gpio_out;
                        T_TMR:   rdata <= timer;
                        default: rdata <= '0;
                    endcase
                end
                if (cur_tgt == T_UNM) bus_err <= 1'b1;
            end
            if (commit && tgt_q == T_GPIO) gpio_out <= wdata_q;
            if (commit && tgt_q == T_TMR)  timer    <= wdata_q;
            else                           timer    <= timer + 32'd1;
        end
    end

    // RAM has no reset; reset forces IDLE, so an abandoned write never commits.
    always_ff @(posedge clk) begin
        if (commit && tgt_q == T_RAM) mem[idx_q] <= wdata_q;
    end

    cfg_lat_range: assert property (@(posedge clk) (RAM_LAT >= 1) && (RAM_LAT <= 15))
        else $error("mio_bus_responder: RAM_LAT out of range 1..15");

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized and directed bench for mio_bus_responder against a
// transaction-level model that tracks completion cycles and target state.
module tb_mio_bus_responder;

    localparam int RAM_AW = 10;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_mio = 1'b0, mem_w = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, gpio_out;
    logic        mio_ready, bus_err;

    logic        b_mio = 1'b0;
    logic [31:0] b_rdata, b_gpio;
    logic        b_ready, b_err;

    always #5 clk = ~clk;

    mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
        .gpio_out(gpio_out), .bus_err(bus_err)
    );

    mio_bus_responder #(.RAM_AW(4), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cpu_mio(b_mio), .mem_w(1'b0), .addr(32'h0000_0008),
        .wdata(32'h0), .rdata(b_rdata), .mio_ready(b_ready),
        .gpio_out(b_gpio), .bus_err(b_err)
    );

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a request completes at an absolute cycle number.
    logic [31:0] m_mem [int];
    int unsigned cyc = 0, done = 0;
    bit          busy = 0, r_w = 0, m_err = 0, chk_en = 0;
    int          r_kind = 3;
    logic [31:0] r_addr = '0, r_wd = '0, m_rdata = '0, m_gpio = '0, m_timer = '0;

    function automatic int kind_of(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 3;
        if ((a >> (RAM_AW + 2)) == 0) return 0;
        if (a == 32'hE000_0000) return 1;
        if (a == 32'hF000_0000) return 2;
        return 3;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [31:0] t_old;
        bit          ld;
        if (!rst) begin
            busy = 0; m_rdata = '0; m_gpio = '0; m_timer = '0; m_err = 0;
        end else begin
            t_old = m_timer;
            ld    = 0;
            if (busy && cyc == done) begin
                if (r_w) begin
                    case (r_kind)
                        0: m_mem[int'(r_addr[RAM_AW+1:2])] = r_wd;
                        1: m_gpio = r_wd;
                        2: begin m_timer = r_wd; ld = 1; end
                        default: ;
                    endcase
                end
                busy = 0;
            end else if (!busy && cpu_mio) begin
                busy   = 1;
                r_w    = mem_w;
                r_addr = addr;
                r_wd   = wdata;
                r_kind = kind_of(addr);
                done   = cyc + ((r_kind == 0) ? LAT : 1);
            end
            if (busy && cyc + 1 == done) begin
                if (!r_w) begin
                    case (r_kind)
                        0: m_rdata = m_mem.exists(int'(r_addr[RAM_AW+1:2])) ?
                                     m_mem[int'(r_addr[RAM_AW+1:2])] : 32'hx;
                        1: m_rdata = m_gpio;
                        2: m_rdata = t_old;
                        default: m_rdata = '0;
                    endcase
                end
                if (r_kind == 3) m_err = 1;
            end
            if (!ld) m_timer = t_old + 32'd1;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {31'b0, mio_ready}, {31'b0, busy && cyc == done});
            chk("cyc_rdata", rdata, m_rdata);
            chk("cyc_gpio", gpio_out, m_gpio);
            chk("cyc_err", {31'b0, bus_err}, {31'b0, m_err});
        end
    end

    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input int exp_lat, input string nm);
        int k = 0;
        bit seen = 0;
        @(negedge clk);
        cpu_mio = 1'b1; mem_w = w; addr = a; wdata = d;
        while (!seen && k < 20) begin
            @(negedge clk);
            cpu_mio = 1'b0;
            k++;
            if (mio_ready) seen = 1;
        end
        chk({nm, "_lat"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r = $urandom_range(0, 9);
        logic [31:0] idx = 32'($urandom_range(0, 15)) << 2;
        if (r <= 5) return idx;
        if (r == 6) return 32'hE000_0000;
        if (r == 7) return 32'hF000_0000;
        if (r == 8) return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h0000_1000;
        return idx | 32'($urandom_range(1, 3));
    endfunction

    initial begin
        int pulses;
        int pos [$];
        rst = 1'b0;
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_ready", {31'b0, mio_ready}, 32'h0);
        rst = 1'b1;

        // Back-to-back RAM reads on the latency-3 instance, request held high.
        @(negedge clk);
        b_mio = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (b_ready) pos.push_back(k);
        end
        b_mio = 1'b0;
        chk("b2b_count", 32'(pos.size()), 32'd3);
        if (pos.size() == 3) begin
            chk("b2b_first", 32'(pos[0]), 32'd3);
            chk("b2b_second", 32'(pos[1]), 32'd7);
            chk("b2b_third", 32'(pos[2]), 32'd11);
        end

        for (int i = 0; i < 16; i++)
            do_access(1, 32'(i) << 2, 32'hA000_0000 | 32'(i), LAT, "init");

        do_access(1, 32'h0000_0010, 32'h1234_5678, 2, "ram_wr");
        do_access(0, 32'h0000_0010, 32'h0, 2, "ram_rd");
        chk("ram_rdata", rdata, 32'h1234_5678);

        do_access(1, 32'hE000_0000, 32'h0000_00A5, 1, "gpio_wr");
        @(negedge clk);
        chk("gpio_val", gpio_out, 32'h0000_00A5);
        do_access(0, 32'hE000_0000, 32'h0, 1, "gpio_rd");
        chk("gpio_rdata", rdata, 32'h0000_00A5);

        do_access(1, 32'hF000_0000, 32'hFFFF_FFFE, 1, "tmr_wr");
        repeat (3) @(negedge clk);
        do_access(0, 32'hF000_0000, 32'h0, 1, "tmr_rd");
        chk("tmr_wrap", rdata, 32'h0000_0001);

        chk("err_before", {31'b0, bus_err}, 32'h0);
        do_access(0, 32'h8000_0000, 32'h0, 1, "unm_rd");
        chk("unm_rdata", rdata, 32'h0);
        chk("unm_err", {31'b0, bus_err}, 32'h1);
        do_access(0, 32'h0000_0002, 32'h0, 1, "misal");
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'b0, bus_err}, 32'h1);

        // Reset lands in the WAIT cycle of a RAM write.
        @(negedge clk);
        cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'h0000_000C; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        cpu_mio = 1'b0;
        #2 rst = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (mio_ready) pulses++;
        end
        chk("rst_no_ready", 32'(pulses), 32'h0);
        chk("rst2_rdata", rdata, 32'h0);
        chk("rst2_gpio", gpio_out, 32'h0);
        chk("rst2_err", {31'b0, bus_err}, 32'h0);
        rst = 1'b1;
        do_access(0, 32'h0000_000C, 32'h0, 2, "post_rst");
        chk("ram_kept", rdata, 32'hA000_0003);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cpu_mio = ($urandom_range(0, 3) != 0);
            mem_w   = $urandom_range(0, 1) == 1;
            addr    = pick_addr();
            wdata   = $urandom;
        end
        cpu_mio = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
